// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_A..SEG_DP : bit positions of each segment inside an 8-bit pattern
//   scan_state_t  : scan FSM states (blank gap / digit drive)
//   hex_to_seg    : 4-bit hex nibble to lit-segment pattern (1 = lit)
package seven_seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Pattern layout: [7]=a ... [1]=g, [0]=dp; dp is never lit here.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] pat;
        case (hex)
            4'h0: pat = 8'hFC;
            4'h1: pat = 8'h60;
            4'h2: pat = 8'hDA;
            4'h3: pat = 8'hF2;
            4'h4: pat = 8'h66;
            4'h5: pat = 8'hB6;
            4'h6: pat = 8'hBE;
            4'h7: pat = 8'hE0;
            4'h8: pat = 8'hFE;
            4'h9: pat = 8'hF6;
            4'hA: pat = 8'hEE;
            4'hB: pat = 8'h3E;
            4'hC: pat = 8'h9C;
            4'hD: pat = 8'h7A;
            4'hE: pat = 8'h9E;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_seg_frame_buffer.sv
// Double-buffered segment store.
//   clk, reset      : clock, async active-high reset
//   wr_en/wr_mask/wr_data : masked write into the pending buffer
//   copy            : frame-boundary strobe from the scan FSM
//   rd_idx/rd_data  : digit pattern read for the scanner
//   dirty           : pending holds writes not yet made active
module seven_seg_frame_buffer #(
    parameter int N_DIGITS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [N_DIGITS-1:0] wr_mask,
    input  logic [7:0]          wr_data,
    input  logic                copy,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [7:0]          rd_data,
    output logic                dirty
);

    logic [N_DIGITS-1:0][7:0] pending;
    logic [N_DIGITS-1:0][7:0] active;
    logic                     do_copy;
    logic                     do_write;

    assign do_copy  = copy && dirty;
    assign do_write = wr_en && (|wr_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            active  <= '0;
            dirty   <= 1'b0;
        end else begin
            // Copy samples pending before any same-cycle write lands.
            if (do_copy)
                active <= pending;
            for (int i = 0; i < N_DIGITS; i++)
                if (wr_en && wr_mask[i])
                    pending[i] <= wr_data;
            // A write coinciding with the copy keeps dirty set so it
            // is picked up at the following boundary.
            if (do_write)
                dirty <= 1'b1;
            else if (do_copy)
                dirty <= 1'b0;
        end
    end

    // Bypass so the first registered seg value of a frame already
    // reflects the buffer being copied at that same edge.
    assign rd_data = do_copy ? pending[rd_idx] : active[rd_idx];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
//   clk, reset     : clock, async active-high reset
//   wr_en/wr_mask/wr_data : MCU masked pattern write (1 = lit)
//   brightness     : PWM on-time (brightness+1)/16 of each drive phase
//   seg            : segment pins, polarity by SEG_ACTIVE_LOW
//   dig            : one-hot digit enables, polarity by DIG_ACTIVE_LOW
//   frame_start    : pulse in the first drive cycle of digit 0
//   update_pending : written data not yet shown
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int DIGIT_CYCLES   = 6144,
    parameter int BLANK_CYCLES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [N_DIGITS-1:0] wr_mask,
    input  logic [7:0]          wr_data,
    input  logic [3:0]          brightness,
    output logic [7:0]          seg,
    output logic [N_DIGITS-1:0] dig,
    output logic                frame_start,
    output logic                update_pending
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ON_W    = $clog2(DIGIT_CYCLES + 1);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [ON_W-1:0]     ON_STEP    = ON_W'(DIGIT_CYCLES / 16);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] DIG_OFF    = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nx;
    logic [ON_W-1:0]     on_q, on_d, on_new;
    logic [7:0]          lit_d;
    logic [N_DIGITS-1:0] dig_en_d;
    logic                fs_d;
    logic                copy;
    logic [7:0]          rd_data;

    seven_seg_frame_buffer #(
        .N_DIGITS (N_DIGITS),
        .IDX_W    (IDX_W)
    ) u_fbuf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_mask (wr_mask),
        .wr_data (wr_data),
        .copy    (copy),
        .rd_idx  (idx_q),
        .rd_data (rd_data),
        .dirty   (update_pending)
    );

    // Max result is 16*(DIGIT_CYCLES/16) = DIGIT_CYCLES, fits ON_W.
    assign on_new = ON_W'({1'b0, brightness} + 5'd1) * ON_STEP;
    assign cnt_nx = cnt_q + CNT_W'(1);

    // Outputs are computed for the next cycle and registered, so seg,
    // dig and frame_start all switch together on one edge.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_nx;
        on_d     = on_q;
        lit_d    = '0;
        dig_en_d = '0;
        fs_d     = 1'b0;
        copy     = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d  = ST_DRIVE;
                    cnt_d    = '0;
                    on_d     = on_new;
                    dig_en_d = N_DIGITS'(1) << idx_q;
                    // on_new >= 2 always, so drive cycle 0 is lit.
                    lit_d    = rd_data;
                    if (idx_q == '0) begin
                        fs_d = 1'b1;
                        copy = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    dig_en_d = N_DIGITS'(1) << idx_q;
                    if (cnt_nx < CNT_W'(on_q))
                        lit_d = rd_data;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            on_q        <= '0;
            seg         <= SEG_OFF;
            dig         <= DIG_OFF;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            on_q        <= on_d;
            seg         <= lit_d ^ SEG_OFF;
            dig         <= dig_en_d ^ DIG_OFF;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: two instances (active-low and
// active-high pins) share stimulus; each completed digit drive phase
// is compared against an expected record queued by the stimulus.
module tb_seven_seg_scan_ctrl;
    import seven_seg_pkg::*;

    localparam int ND     = 4;
    localparam int DC     = 32;
    localparam int BC     = 4;
    localparam int PERIOD = ND * (DC + BC);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_mask = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] brightness = 4'd15;
    logic [7:0] seg_a, seg_b;
    logic [3:0] dig_a, dig_b;
    logic       fs_a, fs_b, up_a, up_b;

    seven_seg_scan_ctrl #(
        .N_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_mask(wr_mask),
        .wr_data(wr_data), .brightness(brightness), .seg(seg_a),
        .dig(dig_a), .frame_start(fs_a), .update_pending(up_a)
    );

    seven_seg_scan_ctrl #(
        .N_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_mask(wr_mask),
        .wr_data(wr_data), .brightness(brightness), .seg(seg_b),
        .dig(dig_b), .frame_start(fs_b), .update_pending(up_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dig;
        logic [7:0] pat;
        int         lit;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // ---------------- monitor state (index 0 = dut_a, 1 = dut_b)
    logic       in_drv[2];
    logic [3:0] cur[2];
    logic [7:0] pat[2];
    int         lit[2], drv[2], gap[2], gap_rec[2], fs_cnt[2];
    logic       fs_first[2], bad[2], seen_off[2];
    int         cyc_cnt = 0;
    int         last_fs = 0;
    logic       have_fs = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic close_phase(input int k);
        exp_t e;
        logic fs_ok;
        checks++;
        if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
            errors++;
            $display("FAIL phase_unexpected dut%0d: got dig=%b pat=%h", k, cur[k], pat[k]);
        end else begin
            if (k == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            fs_ok = (e.dig == 0) ? (fs_first[k] && fs_cnt[k] == 1) : (fs_cnt[k] == 0);
            if (cur[k] != (4'b0001 << e.dig) || pat[k] != e.pat || lit[k] != e.lit ||
                drv[k] != DC || gap_rec[k] != BC || !fs_ok || bad[k]) begin
                errors++;
                $display("FAIL phase dut%0d: got dig=%b pat=%h lit=%0d drv=%0d gap=%0d fs_cnt=%0d fs_first=%0d bad=%0d want dig=%0d pat=%h lit=%0d drv=%0d gap=%0d",
                         k, cur[k], pat[k], lit[k], drv[k], gap_rec[k], fs_cnt[k], fs_first[k], bad[k],
                         e.dig, e.pat, e.lit, DC, BC);
            end
        end
        bad[k] = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [3:0] dl;
        logic [7:0] sl;
        logic       fs;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                in_drv[k] = 1'b0; gap[k] = 0; bad[k] = 1'b0;
            end
            have_fs = 1'b0;
        end else begin
            cyc_cnt++;
            if (fs_a) begin
                if (have_fs) chk("frame_period", cyc_cnt - last_fs, PERIOD);
                have_fs = 1'b1;
                last_fs = cyc_cnt;
            end
            for (int k = 0; k < 2; k++) begin
                dl = (k == 0) ? ~dig_a : dig_b;
                sl = (k == 0) ? ~seg_a : seg_b;
                fs = (k == 0) ? fs_a : fs_b;
                if (dl == '0) begin
                    if (in_drv[k]) begin
                        close_phase(k);
                        in_drv[k] = 1'b0;
                        gap[k]    = 0;
                    end
                    gap[k]++;
                    if (sl != '0 || fs) bad[k] = 1'b1;
                end else begin
                    if (!in_drv[k]) begin
                        in_drv[k]   = 1'b1;
                        cur[k]      = dl;
                        drv[k]      = 0;
                        lit[k]      = 0;
                        pat[k]      = '0;
                        fs_cnt[k]   = 0;
                        fs_first[k] = fs;
                        seen_off[k] = 1'b0;
                        gap_rec[k]  = gap[k];
                        gap[k]      = 0;
                    end
                    drv[k]++;
                    if (dl != cur[k]) bad[k] = 1'b1;
                    if (fs) fs_cnt[k]++;
                    if (sl != '0) begin
                        // lit cycles must form one prefix of the phase
                        if (seen_off[k]) bad[k] = 1'b1;
                        if (lit[k] == 0) pat[k] = sl;
                        else if (sl != pat[k]) bad[k] = 1'b1;
                        lit[k]++;
                    end else begin
                        seen_off[k] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] m, input logic [7:0] d);
        wr_en = 1'b1; wr_mask = m; wr_data = d;
        cyc(1);
        wr_en = 1'b0; wr_mask = '0; wr_data = '0;
    endtask

    task automatic push_exp(input int d, input logic [7:0] p, input int l);
        exp_t e;
        e.dig = d; e.pat = p; e.lit = l;
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic expect_frame(input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [7:0] p3,
                                input int l0, input int l1, input int l2, input int l3);
        push_exp(0, p0, l0);
        push_exp(1, p1, l1);
        push_exp(2, p2, l2);
        push_exp(3, p3, l3);
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_a && n < 4 * PERIOD);
        checks++;
        if (!fs_a) begin
            errors++;
            $display("FAIL frame_start_%s: got timeout after %0d cycles want pulse", tag, n);
        end
    endtask

    initial begin
        chk("hex_0", hex_to_seg(4'h0), 8'hFC);
        chk("hex_5", hex_to_seg(4'h5), 8'hB6);
        chk("hex_A", hex_to_seg(4'hA), 8'hEE);

        cyc(3);
        chk("rst_seg_a", seg_a, 8'hFF);
        chk("rst_dig_a", dig_a, 4'hF);
        chk("rst_seg_b", seg_b, 8'h00);
        chk("rst_dig_b", dig_b, 4'h0);
        chk("rst_fs", fs_a, 1'b0);
        chk("rst_up", up_a, 1'b0);

        // Frame A: nothing written, all dark.
        expect_frame(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        reset = 1'b0;
        wait_fs("A");
        chk("up_A", up_a, 1'b0);
        cyc(10);
        chk("up_before_wr", up_a, 1'b0);
        do_write(4'b0101, 8'hFC);
        chk("up_after_wr", up_a, 1'b1);
        chk("up_after_wr_b", up_b, 1'b1);

        // Frame B: digits 0 and 2 show FC.
        expect_frame(8'hFC, 8'h00, 8'hFC, 8'h00, DC, 0, DC, 0);
        wait_fs("B");
        chk("up_fall_B", up_a, 1'b0);
        // Frame C gets the mid-frame write to digit 1 but not the write
        // sampled on the boundary edge.
        expect_frame(8'hFC, 8'h60, 8'hFC, 8'h00, DC, DC, DC, 0);
        cyc(20);
        do_write(4'b0010, 8'h60);
        cyc(122);
        do_write(4'b0001, 8'hB6);
        wait_fs("C");
        chk("up_hold_C", up_a, 1'b1);

        // Frame D: boundary write appears; brightness 3 from digit 1 on.
        expect_frame(8'hB6, 8'h60, 8'hFC, 8'h00, DC, 8, 8, 0);
        wait_fs("D");
        chk("up_fall_D", up_a, 1'b0);
        cyc(10);
        brightness = 4'd3;

        // Frame E: back to full brightness mid digit 1 -> applies at digit 2.
        expect_frame(8'hB6, 8'h60, 8'hFC, 8'h00, 8, 8, DC, 0);
        wait_fs("E");
        cyc(50);
        brightness = 4'd15;

        // Frame F: reset lands in digit 0 drive with a write pending.
        wait_fs("F");
        cyc(5);
        do_write(4'b1111, 8'hFF);
        chk("up_before_rst", up_a, 1'b1);
        cyc(4);
        chk("drive_before_rst", dig_a, 4'b1110);
        reset = 1'b1;
        #1;
        chk("rst_mid_seg_a", seg_a, 8'hFF);
        chk("rst_mid_dig_a", dig_a, 4'hF);
        chk("rst_mid_seg_b", seg_b, 8'h00);
        chk("rst_mid_dig_b", dig_b, 4'h0);
        chk("rst_mid_up", up_a, 1'b0);
        chk("queue_empty_F", qa.size(), 0);
        cyc(3);

        // Frame G: buffers cleared; Frame H: digit 3 written after reset.
        expect_frame(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        reset = 1'b0;
        wait_fs("G");
        cyc(10);
        do_write(4'b1000, 8'hEE);
        expect_frame(8'h00, 8'h00, 8'h00, 8'hEE, 0, 0, 0, DC);
        wait_fs("H");
        chk("up_fall_H", up_a, 1'b0);

        begin
            int n;
            n = 0;
            while ((qa.size() != 0 || qb.size() != 0) && n < 2 * PERIOD) begin
                @(negedge clk);
                n++;
            end
        end
        chk("queue_drain_a", qa.size(), 0);
        chk("queue_drain_b", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
